fifo_sync_param: RTL and testbench
==================================

FIFO_SYNC_PARAM -- requirements
Module: fifo_sync_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, storage entries; power of two, >=4.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, occupancy at or above which almost_full asserts; 0 < AF_LEVEL < DEPTH.
REQ-004 SHALL have parameter AE_LEVEL, default 2, occupancy at or below which almost_empty asserts; 0 <= AE_LEVEL < AF_LEVEL.
REQ-005 SHALL have parameter FWFT, default 0, read mode: 0 = registered-read, 1 = first-word-fall-through.
REQ-006 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port clear  input  1  synchronous flush, active-high.
REQ-009 SHALL have port wr_en  input  1  write request.
REQ-010 SHALL have port d_in  input  WIDTH  write data.
REQ-011 SHALL have port rd_en  input  1  read request (FWFT=1: acknowledge of head word).
REQ-012 SHALL have port d_out  output  WIDTH  read data.
REQ-013 SHALL have port valid  output  1  d_out holds a valid word.
REQ-014 SHALL have port full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-016 SHALL have port overflow, underflow  output  1 each  one-cycle error pulses.

Function
REQ-017 SHALL accept a write iff wr_en && !full, storing d_in at wr_ptr and advancing wr_ptr modulo DEPTH.
REQ-018 SHALL accept a read iff rd_en && !empty, advancing rd_ptr modulo DEPTH.
REQ-019 SHALL use full/empty as held in the current cycle for acceptance; write to a full FIFO is rejected even when a read is accepted in the same cycle.
REQ-020 SHALL update count: +1 write only, -1 read only, unchanged for both or neither.
REQ-021 SHALL register all flags from the next count, so flags and count change on the same edge: empty = (count==0), full = (count==DEPTH), almost_full = (count>=AF_LEVEL), almost_empty = (count<=AE_LEVEL).
REQ-022 SHALL, with FWFT=0, load d_out with mem[rd_ptr] on the edge of an accepted read and assert valid for exactly the following cycle; d_out holds its value otherwise (read latency 1 cycle).
REQ-023 SHALL, with FWFT=1, present mem[rd_ptr] on d_out with valid = !empty; a word written into an empty FIFO appears on d_out with valid one cycle after the write edge; an accepted read shows the next word (or valid=0) in the following cycle.
REQ-024 SHALL pulse overflow for one cycle after an edge where wr_en && full, and underflow for one cycle after an edge where rd_en && empty; neither alters pointers, count or memory.
REQ-025 SHALL, on clear, set pointers and count to 0, empty=1, almost_empty=1, full=0, almost_full=0, valid=0, overflow=0, underflow=0; d_out retains its value; clear overrides wr_en/rd_en in the same cycle.
REQ-026 SHALL wrap pointers from DEPTH-1 to 0 with no gap or lost word.

Reset
REQ-027 SHALL, on rst, set d_out=0, valid=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, pointers=0; memory contents are not reset.
REQ-028 SHALL give rst priority over clear, wr_en and rd_en; rst asserted mid-operation discards all stored words by the next edge.

Verification (defaults unless stated)
REQ-029 SHALL verify fill: 16 writes 0x00..0x0F -> count 1..16, almost_full at count=14, full at 16; 17th write -> overflow pulse, count stays 16.
REQ-030 SHALL verify drain FWFT=0: 16 reads -> d_out 0x00..0x0F, each one cycle after its read, valid pulses; empty at count 0; extra read -> underflow pulse, d_out holds 0x0F.
REQ-031 SHALL verify wrap: write 10, read 10, write 12, read 12 -> data in order, pointers crossed 15->0, count returns to 0.
REQ-032 SHALL verify simultaneous: count=5, wr_en=rd_en=1 for 4 cycles -> count stays 5, order preserved; at full with both -> read accepted, write rejected, overflow=1, count=15.
REQ-033 SHALL verify FWFT=1: write 0xA5 into empty -> d_out=0xA5, valid=1 next cycle; rd_en=1 one cycle -> valid=0, empty=1.
REQ-034 SHALL verify clear/reset: count=9, clear with wr_en=1 -> count=0, empty=1, no write stored; rst with clear=1 at count=3 -> all REQ-027 values.

Source files
------------

// File: rtl/fifo_sync_param.sv
// Single-clock parameterized FIFO with registered-read or first-word-fall-through
// output, registered status flags and one-cycle overflow/underflow error pulses.
module fifo_sync_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         d_in,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         d_out,
  output logic                     valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] L_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] L_AF    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] L_AE    = CW'(AE_LEVEL);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_dout;
  logic             r_valid, r_full, r_empty, r_af, r_ae, r_ovf, r_unf;

  logic             w_wr_acc, w_rd_acc;
  logic [CW-1:0]    w_cnt_nxt;

  // Acceptance uses the flags held this cycle, so a write into a full FIFO is
  // refused even if a read frees a slot on the same edge.
  assign w_wr_acc = wr_en && !r_full  && !rst && !clear;
  assign w_rd_acc = rd_en && !r_empty && !rst && !clear;

  always_comb begin
    w_cnt_nxt = r_count;
    if (w_wr_acc && !w_rd_acc)      w_cnt_nxt = r_count + CW'(1);
    else if (w_rd_acc && !w_wr_acc) w_cnt_nxt = r_count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= '0;
      r_valid  <= 1'b0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_af     <= 1'b0;
      r_ae     <= 1'b1;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_af     <= 1'b0;
      r_ae     <= 1'b1;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_dout   <= r_mem[r_rd_ptr];
      end
      r_valid <= w_rd_acc;
      r_count <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == L_DEPTH);
      r_empty <= (w_cnt_nxt == '0);
      r_af    <= (w_cnt_nxt >= L_AF);
      r_ae    <= (w_cnt_nxt <= L_AE);
      r_ovf   <= wr_en && r_full;
      r_unf   <= rd_en && r_empty;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= d_in;
  end

  // In FWFT mode the head word is shown directly; once drained, the last
  // consumed word (captured in r_dout) is held so d_out never goes unknown.
  assign d_out        = (FWFT != 0 && !r_empty) ? r_mem[r_rd_ptr] : r_dout;
  assign valid        = (FWFT != 0) ? !r_empty : r_valid;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;
endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: registered-read instance plus an FWFT instance.
module tb_fifo_sync_param;
  logic       clk = 1'b0;
  logic       rst, clear, wr_en, rd_en;
  logic [7:0] d_in, d_out;
  logic       valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  logic       f_clear, f_wr, f_rd;
  logic [7:0] f_din, f_dout;
  logic       f_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [4:0] f_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fifo_sync_param #(.WIDTH(8), .DEPTH(16), .FWFT(0)) u_dut (
    .clk(clk), .rst(rst), .clear(clear), .wr_en(wr_en), .d_in(d_in), .rd_en(rd_en),
    .d_out(d_out), .valid(valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  fifo_sync_param #(.WIDTH(8), .DEPTH(16), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .clear(f_clear), .wr_en(f_wr), .d_in(f_din), .rd_en(f_rd),
    .d_out(f_dout), .valid(f_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_cnt),
    .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Count plus the four level flags expected for occupancy c (AF=14, AE=2, DEPTH=16).
  task automatic chk_lvl(input string tag, input int c);
    chk({tag, " count"}, 32'(count), 32'(c));
    chk({tag, " empty"}, 32'(empty), 32'(c == 0));
    chk({tag, " full"},  32'(full),  32'(c == 16));
    chk({tag, " af"},    32'(almost_full),  32'(c >= 14));
    chk({tag, " ae"},    32'(almost_empty), 32'(c <= 2));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0; d_in = 8'h00;
    f_clear = 1'b0; f_wr = 1'b0; f_rd = 1'b0; f_din = 8'h00;
    step(); step();
    rst = 1'b0;
    chk_lvl("reset", 0);
    chk("reset d_out", 32'(d_out), 32'h0);
    chk("reset valid", 32'(valid), 32'h0);
    chk("reset ovf", 32'(overflow), 32'h0);
    chk("reset unf", 32'(underflow), 32'h0);
    chk("fwft reset valid", 32'(f_valid), 32'h0);

    // Fill 0x00..0x0F, then one rejected write
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; d_in = 8'(i);
      step();
      chk_lvl($sformatf("fill%0d", i), i + 1);
    end
    d_in = 8'hEE;
    step();
    chk("fill17 ovf", 32'(overflow), 32'h1);
    chk_lvl("fill17", 16);
    wr_en = 1'b0;
    step();
    chk("ovf one-shot", 32'(overflow), 32'h0);

    // Drain: data one cycle after each read
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      step();
      chk($sformatf("drain%0d d_out", i), 32'(d_out), 32'(i));
      chk($sformatf("drain%0d valid", i), 32'(valid), 32'h1);
      chk_lvl($sformatf("drain%0d", i), 15 - i);
    end
    step();
    chk("extra rd unf", 32'(underflow), 32'h1);
    chk("extra rd valid", 32'(valid), 32'h0);
    chk("extra rd d_out", 32'(d_out), 32'h0F);
    rd_en = 1'b0;
    step();
    chk("unf one-shot", 32'(underflow), 32'h0);

    // Wrap: write 10 / read 10 / write 12 / read 12
    for (int i = 0; i < 10; i++) begin wr_en = 1'b1; d_in = 8'(8'h20 + i); step(); end
    wr_en = 1'b0;
    chk_lvl("wrap w10", 10);
    for (int i = 0; i < 10; i++) begin
      rd_en = 1'b1; step();
      chk($sformatf("wrap r%0d", i), 32'(d_out), 32'(8'h20 + i));
    end
    rd_en = 1'b0;
    for (int i = 0; i < 12; i++) begin wr_en = 1'b1; d_in = 8'(8'h40 + i); step(); end
    wr_en = 1'b0;
    chk_lvl("wrap w12", 12);
    for (int i = 0; i < 12; i++) begin
      rd_en = 1'b1; step();
      chk($sformatf("wrap2 r%0d", i), 32'(d_out), 32'(8'h40 + i));
    end
    rd_en = 1'b0;
    chk_lvl("wrap end", 0);

    // Simultaneous read+write at count 5
    for (int i = 0; i < 5; i++) begin wr_en = 1'b1; d_in = 8'(8'h60 + i); step(); end
    chk_lvl("sim pre", 5);
    for (int k = 0; k < 4; k++) begin
      wr_en = 1'b1; rd_en = 1'b1; d_in = 8'(8'h65 + k);
      step();
      chk($sformatf("sim%0d d_out", k), 32'(d_out), 32'(8'h60 + k));
      chk_lvl($sformatf("sim%0d", k), 5);
    end
    rd_en = 1'b0;
    for (int j = 0; j < 11; j++) begin wr_en = 1'b1; d_in = 8'(8'h69 + j); step(); end
    chk_lvl("sim full", 16);
    wr_en = 1'b1; rd_en = 1'b1; d_in = 8'hFF;
    step();
    chk("full both d_out", 32'(d_out), 32'h64);
    chk("full both ovf", 32'(overflow), 32'h1);
    chk_lvl("full both", 15);
    wr_en = 1'b0; rd_en = 1'b0;

    // Clear from 15, then clear with a concurrent write at count 9
    clear = 1'b1; step(); clear = 1'b0;
    chk_lvl("clear15", 0);
    chk("clear15 valid", 32'(valid), 32'h0);
    chk("clear15 ovf", 32'(overflow), 32'h0);
    for (int i = 0; i < 9; i++) begin wr_en = 1'b1; d_in = 8'(8'h80 + i); step(); end
    chk_lvl("pre clear9", 9);
    clear = 1'b1; wr_en = 1'b1; d_in = 8'hCC;
    step();
    clear = 1'b0; wr_en = 1'b0;
    chk_lvl("clear9", 0);
    chk("clear keeps d_out", 32'(d_out), 32'h64);
    rd_en = 1'b1; step(); rd_en = 1'b0;
    chk("clear no store unf", 32'(underflow), 32'h1);
    chk("clear no store valid", 32'(valid), 32'h0);
    wr_en = 1'b1; d_in = 8'h11; step(); wr_en = 1'b0;
    rd_en = 1'b1; step(); rd_en = 1'b0;
    chk("post clear d_out", 32'(d_out), 32'h11);
    chk_lvl("post clear", 0);

    // Reset beats clear/write at count 3
    for (int i = 0; i < 3; i++) begin wr_en = 1'b1; d_in = 8'(8'h90 + i); step(); end
    chk_lvl("pre rst", 3);
    rst = 1'b1; clear = 1'b1; wr_en = 1'b1; d_in = 8'hDD;
    step();
    rst = 1'b0; clear = 1'b0; wr_en = 1'b0;
    chk_lvl("rst", 0);
    chk("rst d_out", 32'(d_out), 32'h0);
    chk("rst valid", 32'(valid), 32'h0);
    chk("rst ovf", 32'(overflow), 32'h0);
    chk("rst unf", 32'(underflow), 32'h0);
    rd_en = 1'b1; step(); rd_en = 1'b0;
    chk("rst discards unf", 32'(underflow), 32'h1);
    chk("rst discards valid", 32'(valid), 32'h0);

    // FWFT instance
    f_wr = 1'b1; f_din = 8'hA5; step(); f_wr = 1'b0;
    chk("fwft d_out", 32'(f_dout), 32'hA5);
    chk("fwft valid", 32'(f_valid), 32'h1);
    chk("fwft count", 32'(f_cnt), 32'h1);
    f_rd = 1'b1; step(); f_rd = 1'b0;
    chk("fwft rd valid", 32'(f_valid), 32'h0);
    chk("fwft rd empty", 32'(f_empty), 32'h1);
    f_wr = 1'b1; f_din = 8'h3C; step();
    chk("fwft head", 32'(f_dout), 32'h3C);
    f_din = 8'h5A; step(); f_wr = 1'b0;
    chk("fwft head hold", 32'(f_dout), 32'h3C);
    f_rd = 1'b1; step();
    chk("fwft next", 32'(f_dout), 32'h5A);
    chk("fwft next valid", 32'(f_valid), 32'h1);
    step(); f_rd = 1'b0;
    chk("fwft drained valid", 32'(f_valid), 32'h0);
    chk("fwft drained empty", 32'(f_empty), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
